// File: rtl/cfg_prog_pkg.sv
// Shared types and elaboration helpers for the bl/wl configuration writer.
// Width helpers are functions so that module headers can size ports from parameters.
package cfg_prog_pkg;

   localparam int MAX_WL = 64;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETUP,
      PULSE,
      HOLD,
      DONE
   } cfg_state_e;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic logic [MAX_WL-1:0] onehot(input int row, input int width);
      logic [MAX_WL-1:0] v;
      v = '0;
      if (row >= 0 && row < width && row < MAX_WL) v[row] = 1'b1;
      return v;
   endfunction

   localparam int DEF_NWORDS = ceil_div(315, 32);
   localparam int DEF_WC_W   = cnt_w(DEF_NWORDS);
   localparam int DEF_ROW_W  = cnt_w(4);

endpackage

// File: rtl/cfg_phase_timer.sv
// Loadable down-counter timing the SETUP, PULSE and HOLD phases.
// Loading N-1 on phase entry makes expired rise in the N-th cycle of the phase.
module cfg_phase_timer #(
   parameter int W = 1
) (
   input  logic         prog_clk,
   input  logic         prog_rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n)       cnt <= '0;
      else if (load)         cnt <= load_val;
      else if (cnt != '0)    cnt <= cnt - 1'b1;
   end

   assign expired = (cnt == '0);

endmodule

// File: rtl/bl_wl_config_writer.sv
// Writer end of the tile bl/wl configuration chain: assembles one bit-line row
// from the word stream, then strobes its one-hot word line, for every row.
module bl_wl_config_writer
   import cfg_prog_pkg::*;
#(
   parameter int BL_WIDTH  = 315,
   parameter int WL_WIDTH  = 4,
   parameter int DATA_W    = 32,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic                         prog_clk,
   input  logic                         prog_rst_n,
   input  logic                         start,
   input  logic                         abort,
   input  logic [DATA_W-1:0]            s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic [BL_WIDTH-1:0]          bl_out,
   output logic [WL_WIDTH-1:0]          wl_out,
   output logic [cnt_w(WL_WIDTH)-1:0]   row_idx,
   output logic                         busy,
   output logic                         done
);

   localparam int NWORDS  = ceil_div(BL_WIDTH, DATA_W);
   localparam int WC_W    = cnt_w(NWORDS);
   localparam int RW      = cnt_w(WL_WIDTH);
   localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC)
                            ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                            : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
   localparam int TW      = cnt_w(MAX_CYC);

   if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1 || BL_WIDTH < 1 ||
       WL_WIDTH < 1 || WL_WIDTH > MAX_WL || DATA_W < 1) begin : g_param_err
      $error("bl_wl_config_writer: illegal parameter set");
   end

   cfg_state_e          state, state_d;
   logic [WC_W-1:0]     word_cnt;
   logic [BL_WIDTH-1:0] bl_wr;
   logic                hs, kill, last_word, last_row;
   logic                tmr_load, tmr_exp;
   logic [TW-1:0]       tmr_val;

   assign s_ready   = (state == LOAD);
   assign hs        = s_valid && s_ready;
   assign kill      = abort && (state != IDLE);
   assign last_word = (word_cnt == WC_W'(NWORDS - 1));
   assign last_row  = (row_idx == RW'(WL_WIDTH - 1));

   cfg_phase_timer #(.W(TW)) u_timer (
      .prog_clk   (prog_clk),
      .prog_rst_n (prog_rst_n),
      .load       (tmr_load),
      .load_val   (tmr_val),
      .expired    (tmr_exp)
   );

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) state <= IDLE;
      else             state <= state_d;
   end

   always_comb begin
      state_d  = state;
      tmr_load = 1'b0;
      tmr_val  = '0;
      if (kill) begin
         state_d = IDLE;
      end else begin
         case (state)
            IDLE:  if (start && !abort) state_d = LOAD;
            LOAD:  if (hs && last_word) begin
                      state_d  = SETUP;
                      tmr_load = 1'b1;
                      tmr_val  = TW'(SETUP_CYC - 1);
                   end
            SETUP: if (tmr_exp) begin
                      state_d  = PULSE;
                      tmr_load = 1'b1;
                      tmr_val  = TW'(PULSE_CYC - 1);
                   end
            PULSE: if (tmr_exp) begin
                      state_d  = HOLD;
                      tmr_load = 1'b1;
                      tmr_val  = TW'(HOLD_CYC - 1);
                   end
            HOLD:  if (tmr_exp) state_d = last_row ? DONE : LOAD;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Current word lands at its slot; bits past BL_WIDTH in the last word fall away.
   always_comb begin
      bl_wr = bl_out;
      for (int i = 0; i < BL_WIDTH; i++)
         if (i / DATA_W == int'(word_cnt)) bl_wr[i] = s_data[i % DATA_W];
   end

   // Outputs follow the next state so wl_out is high exactly while in PULSE.
   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         bl_out   <= '0;
         wl_out   <= '0;
         row_idx  <= '0;
         word_cnt <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done   <= (state_d == DONE);
         busy   <= (state_d inside {LOAD, SETUP, PULSE, HOLD});
         wl_out <= (state_d == PULSE) ? WL_WIDTH'(onehot(int'(row_idx), WL_WIDTH)) : '0;
         if (kill) begin
            bl_out   <= '0;
            row_idx  <= '0;
            word_cnt <= '0;
         end else begin
            case (state)
               IDLE: if (state_d == LOAD) begin
                        row_idx  <= '0;
                        word_cnt <= '0;
                     end
               LOAD: if (hs) begin
                        bl_out   <= bl_wr;
                        word_cnt <= word_cnt + 1'b1;
                     end
               HOLD: if (state_d == LOAD) begin
                        row_idx  <= row_idx + 1'b1;
                        word_cnt <= '0;
                     end
               DONE: row_idx <= '0;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bl_wl_config_writer.sv
// Self-checking bench: random and directed frames against a row/pulse reference model.
module tb_bl_wl_config_writer;

   localparam int BL = 315, WL = 4, DW = 32, NW = 10, SC = 1, PC = 2, HC = 1;
   typedef logic [319:0] cv_t;

   logic prog_clk = 1'b0, prog_rst_n = 1'b0;
   always #5 prog_clk = ~prog_clk;

   logic          start = 1'b0, abort = 1'b0, s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready, busy, done;
   logic [BL-1:0] bl_out;
   logic [WL-1:0] wl_out;
   logic [1:0]    row_idx;

   logic          start6 = 1'b0, abort6 = 1'b0, s6_valid = 1'b0;
   logic [31:0]   s6_data = '0;
   logic          s6_ready, busy6, done6;
   logic [63:0]   bl6;
   logic [0:0]    wl6, row6;

   int errs = 0, checks = 0;
   logic [DW-1:0] words [WL*NW];

   bl_wl_config_writer dut (
      .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .bl_out(bl_out),
      .wl_out(wl_out), .row_idx(row_idx), .busy(busy), .done(done));

   bl_wl_config_writer #(.BL_WIDTH(64), .WL_WIDTH(1), .DATA_W(32)) dut6 (
      .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start6), .abort(abort6),
      .s_data(s6_data), .s_valid(s6_valid), .s_ready(s6_ready), .bl_out(bl6),
      .wl_out(wl6), .row_idx(row6), .busy(busy6), .done(done6));

   task automatic chk(input string tag, input cv_t obs, input cv_t exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Row r is words NW*r .. NW*r+NW-1 laid end to end, cut to BL bits.
   function automatic logic [BL-1:0] row_exp(input int r);
      logic [NW*DW-1:0] pad;
      for (int k = 0; k < NW; k++) pad[k*DW +: DW] = words[r*NW + k];
      return pad[BL-1:0];
   endfunction

   // mode 0: back-to-back, 1: s_valid toggling, 2: random data and valid
   task automatic run_frame(input int mode, input int abort_row, input bit poke);
      int q = 0, cyc = 0, plen = 0, rseen = 0, dcnt = 0, post = 0;
      bit hs, fin = 0, ab = 0, ab_now = 0, pk = 0, pk_now = 0;
      logic [BL-1:0] pbl;
      logic [WL-1:0] pwl;
      for (int i = 0; i < WL*NW; i++)
         words[i] = (mode == 2) ? $urandom : 32'hA5A5_0000 + 32'(i);
      pbl = bl_out;
      pwl = '0;
      @(posedge prog_clk); #1;
      start   = 1'b1;
      s_valid = (mode != 2) || ($urandom_range(0, 1) == 1);
      s_data  = words[0];
      @(posedge prog_clk); #1;
      start = 1'b0;
      cyc   = 1;
      while (!fin && cyc < 600) begin
         @(negedge prog_clk);
         chk("wl_onehot", cv_t'($onehot0(wl_out)), cv_t'(1));
         chk("rdy_idle", cv_t'(s_ready && !busy), cv_t'(0));
         if (ab_now) begin
            chk("abort_wl", cv_t'(wl_out), cv_t'(0));
            chk("abort_bl", cv_t'(bl_out), cv_t'(0));
            chk("abort_busy", cv_t'(busy), cv_t'(0));
            chk("abort_rdy", cv_t'(s_ready), cv_t'(0));
            chk("abort_row", cv_t'(row_idx), cv_t'(0));
            ab_now = 0;
         end else if (pwl != '0 || wl_out != '0) begin
            chk("bl_stable", cv_t'(bl_out), cv_t'(pbl));
         end
         if (pk_now) begin
            chk("start_ign_row", cv_t'(row_idx), cv_t'(1));
            chk("start_ign_busy", cv_t'(busy), cv_t'(1));
            pk_now = 0;
         end
         if (s_ready) chk("rdy_wl_low", cv_t'(wl_out), cv_t'(0));
         if (wl_out != '0 && pwl == '0) begin
            chk("wl_row", cv_t'(wl_out), cv_t'(1) << rseen);
            chk("bl_row", cv_t'(bl_out), cv_t'(row_exp(rseen)));
            chk("row_idx", cv_t'(row_idx), cv_t'(rseen));
            plen = 1;
         end else if (wl_out != '0) begin
            plen++;
         end else if (pwl != '0) begin
            chk("pulse_len", cv_t'(plen), cv_t'(PC));
            rseen++;
         end
         if (done) begin
            dcnt++;
            chk("done_after_abort", cv_t'(ab), cv_t'(0));
            chk("rows_at_done", cv_t'(rseen), cv_t'(WL));
            chk("busy_at_done", cv_t'(busy), cv_t'(0));
            if (mode == 0) chk("done_cyc", cv_t'(cyc + 1), cv_t'(2 + WL*(NW + SC + PC + HC)));
            fin = 1;
         end
         if (ab) begin
            post++;
            if (post == 12) fin = 1;
         end
         hs = s_valid && s_ready;
         if (abort_row == rseen && wl_out != '0 && plen == 2 && !ab) begin
            abort = 1'b1; ab = 1; ab_now = 1;
         end
         if (poke && !pk && rseen == 1 && s_ready) begin
            start = 1'b1; pk = 1; pk_now = 1;
         end
         pwl = wl_out;
         pbl = bl_out;
         @(posedge prog_clk); #1;
         cyc++;
         abort = 1'b0;
         start = 1'b0;
         if (hs) q++;
         s_valid = (q < WL*NW) && (mode == 0 || (mode == 1 && cyc % 2 == 0) ||
                                   (mode == 2 && $urandom_range(0, 1) == 1));
         s_data  = words[q % (WL*NW)];
      end
      if (!fin) chk("frame_timeout", cv_t'(0), cv_t'(1));
      s_valid = 1'b0;
      @(negedge prog_clk);
      chk("idle_busy", cv_t'(busy), cv_t'(0));
      chk("idle_row", cv_t'(row_idx), cv_t'(0));
      chk("idle_wl", cv_t'(wl_out), cv_t'(0));
      chk("idle_done", cv_t'(done), cv_t'(0));
      if (!ab) begin
         chk("words_used", cv_t'(q), cv_t'(WL*NW));
         chk("bl_retained", cv_t'(bl_out), cv_t'(row_exp(WL-1)));
         chk("done_count", cv_t'(dcnt), cv_t'(1));
      end else begin
         chk("bl_cleared", cv_t'(bl_out), cv_t'(0));
         chk("done_count", cv_t'(dcnt), cv_t'(0));
      end
   endtask

   initial begin
      int cyc, n, dcyc, plen, pulses;
      bit hs;
      logic [31:0] w0, w1;

      // reset values
      repeat (2) @(posedge prog_clk);
      @(negedge prog_clk);
      chk("rst_bl", cv_t'(bl_out), cv_t'(0));
      chk("rst_wl", cv_t'(wl_out), cv_t'(0));
      chk("rst_rdy", cv_t'(s_ready), cv_t'(0));
      chk("rst_row", cv_t'(row_idx), cv_t'(0));
      chk("rst_busy", cv_t'(busy), cv_t'(0));
      chk("rst_done", cv_t'(done), cv_t'(0));
      @(posedge prog_clk); #1;
      prog_rst_n = 1'b1;

      run_frame(0, -1, 0);
      run_frame(1, -1, 0);
      run_frame(0, 2, 0);
      run_frame(2, -1, 0);

      // start and abort together in IDLE
      @(posedge prog_clk); #1;
      start = 1'b1; abort = 1'b1;
      @(posedge prog_clk); #1;
      start = 1'b0; abort = 1'b0;
      repeat (2) begin
         @(negedge prog_clk);
         chk("sa_busy", cv_t'(busy), cv_t'(0));
         chk("sa_rdy", cv_t'(s_ready), cv_t'(0));
      end

      run_frame(0, -1, 1);

      // asynchronous reset mid-pulse
      @(posedge prog_clk); #1;
      start = 1'b1; s_valid = 1'b1; s_data = $urandom;
      @(posedge prog_clk); #1;
      start = 1'b0;
      cyc = 0;
      while (wl_out == '0 && cyc < 100) begin
         @(negedge prog_clk);
         cyc++;
      end
      chk("rst_pulse_seen", cv_t'(wl_out != '0), cv_t'(1));
      #2 prog_rst_n = 1'b0;
      #1;
      chk("arst_wl", cv_t'(wl_out), cv_t'(0));
      chk("arst_bl", cv_t'(bl_out), cv_t'(0));
      chk("arst_busy", cv_t'(busy), cv_t'(0));
      chk("arst_rdy", cv_t'(s_ready), cv_t'(0));
      chk("arst_row", cv_t'(row_idx), cv_t'(0));
      s_valid = 1'b0;
      @(posedge prog_clk); #1;
      prog_rst_n = 1'b1;

      // 64-bit single-row instance
      w0 = $urandom; w1 = $urandom;
      @(posedge prog_clk); #1;
      start6 = 1'b1; s6_valid = 1'b1; s6_data = w0;
      @(posedge prog_clk); #1;
      start6 = 1'b0;
      cyc = 1; n = 0; dcyc = -1; plen = 0; pulses = 0;
      while (dcyc < 0 && cyc < 50) begin
         @(negedge prog_clk);
         if (wl6[0]) begin
            if (plen == 0) begin
               pulses++;
               chk("f6_bl", cv_t'(bl6), cv_t'({w1, w0}));
            end
            plen++;
         end else if (plen != 0) begin
            chk("f6_pulse_len", cv_t'(plen), cv_t'(PC));
            plen = 0;
         end
         if (done6) dcyc = cyc;
         hs = s6_valid && s6_ready;
         @(posedge prog_clk); #1;
         cyc++;
         if (hs) n++;
         s6_valid = (n < 2);
         s6_data  = (n == 1) ? w1 : w0;
      end
      chk("f6_pulses", cv_t'(pulses), cv_t'(1));
      chk("f6_words", cv_t'(n), cv_t'(2));
      chk("f6_done_cyc", cv_t'(dcyc + 1), cv_t'(2 + (2 + SC + PC + HC)));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
